noc_output_port: RTL and testbench

Output-port stage of the NoC router, instantiated once per output direction (E, W, S, N, PE) directly downstream of the per-input routing stage. It accepts the 64-bit packet and request pulses that the four routing instances targeting this direction produce, and buffers each source in its own FIFO. It returns a per-source `full` flag to the routing stage, round-robin arbitrates among non-empty FIFOs, and drives one registered packet onto the outgoing link with a valid/ready handshake.

---
 rtl/noc_pkg.sv | 32 +++
 rtl/noc_output_port_if.sv | 14 +
 rtl/noc_sync_fifo.sv | 64 ++++++
 rtl/noc_output_port.sv | 120 ++++++++++++
 tb/tb_noc_output_port.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: packet width, direction encoding and
// the per-output-port source ordering used by routing/input/output blocks.
package noc_pkg;
    localparam int DATA_W  = 64;
    localparam int NUM_DIR = 5;

    typedef enum logic [2:0] {
        DIR_E  = 3'd0,
        DIR_W  = 3'd1,
        DIR_S  = 3'd2,
        DIR_N  = 3'd3,
        DIR_PE = 3'd4
    } dir_e;

    typedef logic [3:0][2:0] src_order_t;

    // Sources feeding an output port: all directions in E,W,S,N,PE order
    // with the port's own direction left out. Entry k is source k.
    function automatic src_order_t src_order(dir_e out_dir);
        src_order_t ord;
        int         k;
        ord = '0;
        k   = 0;
        for (int d = 0; d < NUM_DIR; d++) begin
            if (d != int'(out_dir) && k < 4) begin
                ord[k] = 3'(d);
                k++;
            end
        end
        return ord;
    endfunction
endpackage

// File: rtl/noc_output_port_if.sv
// Outgoing link of an output port: registered packet, valid/ready and the
// one-hot source that produced the packet.
interface noc_output_port_if #(
    parameter int DATA_W = noc_pkg::DATA_W,
    parameter int NUM_IN = 4
);
    logic [DATA_W-1:0] out_packet;
    logic              out_valid;
    logic              out_ready;
    logic [NUM_IN-1:0] grant;

    modport master (output out_packet, output out_valid, output grant, input out_ready);
    modport slave  (input out_packet, input out_valid, input grant, output out_ready);
endinterface

// File: rtl/noc_sync_fifo.sv
// Per-source packet FIFO. Pushes into a full FIFO and pops from an empty
// one are ignored; full/empty come straight from the registered count.
module noc_sync_fifo #(
    parameter int DATA_W = noc_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]                  count_q, count_d;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic                         do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state for storage, pointers (natural wrap) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (!do_push && do_pop)
            count_d = count_q - 1'b1;
    end

    // Control state, cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; contents are only visible when count > 0
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/noc_output_port.sv
// NoC router output port: four source FIFOs, round-robin arbiter and a
// registered valid/ready output stage.
module noc_output_port
    import noc_pkg::*;
#(
    parameter int DATA_W = noc_pkg::DATA_W,
    parameter int DEPTH  = 4,
    parameter int NUM_IN = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  in_packet_0,
    input  logic [DATA_W-1:0]  in_packet_1,
    input  logic [DATA_W-1:0]  in_packet_2,
    input  logic [DATA_W-1:0]  in_packet_3,
    input  logic               in_req_0,
    input  logic               in_req_1,
    input  logic               in_req_2,
    input  logic               in_req_3,
    output logic               full_0,
    output logic               full_1,
    output logic               full_2,
    output logic               full_3,
    noc_output_port_if.master  link,
    output logic               overflow
);
    localparam int LGW = $clog2(NUM_IN);

    logic [NUM_IN-1:0][DATA_W-1:0] in_packet, fifo_dout;
    logic [NUM_IN-1:0]             in_req, fifo_full, fifo_empty, pop;

    logic [DATA_W-1:0] out_packet_q, out_packet_d;
    logic              out_valid_q, out_valid_d;
    logic [NUM_IN-1:0] grant_q, grant_d;
    logic [LGW-1:0]    last_grant_q, last_grant_d;
    logic              overflow_q, overflow_d;
    logic              load, found;
    logic [LGW-1:0]    sel;
    int                idx;

    assign in_packet = {in_packet_3, in_packet_2, in_packet_1, in_packet_0};
    assign in_req    = {in_req_3, in_req_2, in_req_1, in_req_0};
    assign {full_3, full_2, full_1, full_0} = fifo_full;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_fifo
            noc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (in_req[gi]),
                .pop   (pop[gi]),
                .din   (in_packet[gi]),
                .dout  (fifo_dout[gi]),
                .full  (fifo_full[gi]),
                .empty (fifo_empty[gi])
            );
        end
    endgenerate

    // Round-robin pick: first non-empty source after the last grant
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_IN;
            if (!found && !fifo_empty[idx]) begin
                found = 1'b1;
                sel   = LGW'(idx);
            end
        end
    end

    // Output register: reload when empty or draining, otherwise hold
    always_comb begin
        load         = !out_valid_q || link.out_ready;
        out_packet_d = out_packet_q;
        out_valid_d  = out_valid_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pop          = '0;
        if (load) begin
            grant_d = '0;
            if (found) begin
                pop[sel]     = 1'b1;
                out_packet_d = fifo_dout[sel];
                out_valid_d  = 1'b1;
                grant_d[sel] = 1'b1;
                last_grant_d = sel;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        // full is the pre-pop view, so a write racing a pop is still dropped
        overflow_d = overflow_q | (|(in_req & fifo_full));
    end

    // Output stage and arbiter state; source 0 wins first after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_packet_q <= '0;
            out_valid_q  <= 1'b0;
            grant_q      <= '0;
            last_grant_q <= LGW'(NUM_IN - 1);
            overflow_q   <= 1'b0;
        end else begin
            out_packet_q <= out_packet_d;
            out_valid_q  <= out_valid_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
        end
    end

    assign link.out_packet = out_packet_q;
    assign link.out_valid  = out_valid_q;
    assign link.grant      = grant_q;
    assign overflow        = overflow_q;
endmodule

// File: tb/tb_noc_output_port.sv
// Directed bench for noc_output_port: latency, fairness, back-pressure,
// same-cycle push/pop, pointer wrap and mid-stream reset.
module tb_noc_output_port;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_packet_0, in_packet_1, in_packet_2, in_packet_3;
    logic        in_req_0, in_req_1, in_req_2, in_req_3;
    logic        full_0, full_1, full_2, full_3;
    logic        overflow;
    int          n_tests = 0;
    int          n_fail  = 0;

    noc_output_port_if #(.DATA_W(64), .NUM_IN(4)) link ();

    noc_output_port #(.DATA_W(64), .DEPTH(4), .NUM_IN(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_packet_0 (in_packet_0),
        .in_packet_1 (in_packet_1),
        .in_packet_2 (in_packet_2),
        .in_packet_3 (in_packet_3),
        .in_req_0    (in_req_0),
        .in_req_1    (in_req_1),
        .in_req_2    (in_req_2),
        .in_req_3    (in_req_3),
        .full_0      (full_0),
        .full_1      (full_1),
        .full_2      (full_2),
        .full_3      (full_3),
        .link        (link),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        in_req_0 = 1'b0; in_req_1 = 1'b0; in_req_2 = 1'b0; in_req_3 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_req();
        link.out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [63:0] pkt);
        chk({tag, "_valid"}, 64'(link.out_valid), 64'd1);
        chk({tag, "_grant"}, 64'(link.grant), 64'(g));
        chk({tag, "_pkt"}, link.out_packet, pkt);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(link.out_valid), 64'd0);
        chk({tag, "_grant"}, 64'(link.grant), 64'd0);
    endtask

    initial begin
        in_packet_0 = '0; in_packet_1 = '0; in_packet_2 = '0; in_packet_3 = '0;
        clr_req();
        link.out_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", 64'(link.out_valid), 64'd0);
        chk("rst_pkt", link.out_packet, 64'd0);
        chk("rst_grant", 64'(link.grant), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_full", 64'({full_3, full_2, full_1, full_0}), 64'd0);

        // Single packet: no bypass, valid one edge after the write
        link.out_ready = 1'b1;
        in_packet_1 = 64'hDEAD_BEEF_0000_0001; in_req_1 = 1'b1;
        tick(); clr_req();
        chk("single_nobypass", 64'(link.out_valid), 64'd0);
        tick();
        chk_out("single", 4'b0010, 64'hDEAD_BEEF_0000_0001);
        tick();
        chk_idle("single_idle");

        // Fairness: two packets per source, stalled during preload
        do_reset();
        in_packet_0 = 64'h00; in_packet_1 = 64'h10; in_packet_2 = 64'h20; in_packet_3 = 64'h30;
        in_req_0 = 1; in_req_1 = 1; in_req_2 = 1; in_req_3 = 1;
        tick();
        in_packet_0 = 64'h01; in_packet_1 = 64'h11; in_packet_2 = 64'h21; in_packet_3 = 64'h31;
        tick(); clr_req();
        chk_out("fair0", 4'b0001, 64'h00);
        link.out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_out($sformatf("fair%0d", i), 4'(1 << (i % 4)), 64'((i % 4) * 16 + i / 4));
        end
        tick();
        chk_idle("fair_idle");

        // Back-pressure: output held by a source-0 packet, fill source 2
        do_reset();
        in_packet_0 = 64'h55; in_req_0 = 1;
        tick(); clr_req();
        tick();
        chk_out("bp_head", 4'b0001, 64'h55);
        for (int i = 0; i < 4; i++) begin
            in_packet_2 = 64'hA0 + 64'(i); in_req_2 = 1;
            tick(); clr_req();
            chk($sformatf("bp_full_w%0d", i), 64'(full_2), (i == 3) ? 64'd1 : 64'd0);
        end
        chk("bp_hold", link.out_packet, 64'h55);
        chk("bp_noovf", 64'(overflow), 64'd0);
        in_packet_2 = 64'hA4; in_req_2 = 1;
        tick(); clr_req();
        chk("bp_ovf", 64'(overflow), 64'd1);
        chk("bp_full_stay", 64'(full_2), 64'd1);
        link.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("bp_out%0d", i), 4'b0100, 64'hA0 + 64'(i));
            if (i == 0) chk("bp_full_fall", 64'(full_2), 64'd0);
        end
        tick();
        chk_idle("bp_drop");
        chk("bp_ovf_sticky", 64'(overflow), 64'd1);

        // Same-cycle push and pop on source 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_packet_0 = 64'hB0 + 64'(i); in_req_0 = 1;
            tick();
        end
        clr_req();
        chk_out("pp_head", 4'b0001, 64'hB0);
        in_packet_0 = 64'hB4; in_req_0 = 1; link.out_ready = 1'b1;
        tick(); clr_req(); link.out_ready = 1'b0;
        chk("pp_pkt1", link.out_packet, 64'hB1);
        chk("pp_nofull", 64'(full_0), 64'd0);
        in_packet_0 = 64'hB5; in_req_0 = 1;
        tick(); clr_req();
        chk("pp_full", 64'(full_0), 64'd1);
        chk("pp_noovf", 64'(overflow), 64'd0);
        in_packet_0 = 64'hB6; in_req_0 = 1; link.out_ready = 1'b1;
        tick(); clr_req();
        chk("pp_pkt2", link.out_packet, 64'hB2);
        chk("pp_ovf", 64'(overflow), 64'd1);
        chk("pp_full_fall", 64'(full_0), 64'd0);
        for (int i = 3; i < 6; i++) begin
            tick();
            chk_out($sformatf("pp_drain%0d", i), 4'b0001, 64'hB0 + 64'(i));
        end
        tick();
        chk_idle("pp_drop");

        // Pointer wrap: 12 packets through source 3 at full rate
        do_reset();
        link.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_packet_3 = 64'hC00 + 64'(i); in_req_3 = 1;
            tick();
            if (i >= 1) chk_out($sformatf("wrap%0d", i - 1), 4'b1000, 64'hC00 + 64'(i - 1));
        end
        clr_req();
        tick();
        chk_out("wrap11", 4'b1000, 64'hC0B);
        tick();
        chk_idle("wrap_idle");

        // Reset while packets are buffered and one is on the link
        do_reset();
        in_packet_1 = 64'hD1; in_packet_3 = 64'hD3; in_req_1 = 1; in_req_3 = 1;
        tick(); clr_req();
        tick();
        chk_out("mid_pre", 4'b0010, 64'hD1);
        do_reset();
        chk("mid_valid", 64'(link.out_valid), 64'd0);
        chk("mid_pkt", link.out_packet, 64'd0);
        chk("mid_grant", 64'(link.grant), 64'd0);
        link.out_ready = 1'b1;
        in_packet_0 = 64'hF0; in_packet_2 = 64'hF2; in_req_0 = 1; in_req_2 = 1;
        tick(); clr_req();
        tick();
        chk_out("mid_g0", 4'b0001, 64'hF0);
        tick();
        chk_out("mid_g2", 4'b0100, 64'hF2);
        tick();
        chk_idle("mid_nostale");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
